// File: rtl/counter_timer_seq.sv
// rtl/counter_timer_seq.sv - arm/monitor/cancel sequencer for a chained 64-bit down-counting timer
//
// Drives the register-write ports of a low-word and a high-word counter_timer
// core to load a 64-bit count and enable the chain, then watches the high
// core's irq and reports each expiry.
//
// Ports:
//   clkin, resetn          clock, asynchronous active-low reset
//   req_valid/req_ready    request handshake (ready only in IDLE)
//   req_count/req_periodic 64-bit timeout and reload mode, latched on accept
//   cancel                 level, aborts an arming or running timer
//   ct_wdata               shared write data to both cores
//   lo_*_we / hi_*_we      per-core value, data and config write strobes
//   hi_irq                 expiry pulse from the high core
//   busy, expired, cancelled, expire_cnt   status outputs
module counter_timer_seq #(
    parameter int EXP_CNT_W   = 8,
    parameter int IRQ_STRETCH = 0
) (
    input  logic                 clkin,
    input  logic                 resetn,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [63:0]          req_count,
    input  logic                 req_periodic,
    input  logic                 cancel,
    output logic [31:0]          ct_wdata,
    output logic [3:0]           lo_val_we,
    output logic [3:0]           lo_dat_we,
    output logic                 lo_cfg_we,
    output logic [3:0]           hi_val_we,
    output logic [3:0]           hi_dat_we,
    output logic                 hi_cfg_we,
    input  logic                 hi_irq,
    output logic                 busy,
    output logic                 expired,
    output logic                 cancelled,
    output logic [EXP_CNT_W-1:0] expire_cnt
);

    typedef enum logic [3:0] {
        IDLE,
        W_LO_VAL,
        W_HI_VAL,
        W_LO_DAT,
        W_HI_DAT,
        W_HI_CFG,
        W_LO_CFG,
        RUN,
        D_HI,
        D_LO
    } state_t;

    localparam logic [1:0] STRETCH = IRQ_STRETCH[1:0];

    state_t                 state_q, state_d;
    logic [63:0]            count_q, count_d;
    logic                   periodic_q, periodic_d;
    logic [EXP_CNT_W-1:0]   cnt_q, cnt_d;
    logic                   cxl_q, cxl_d;
    logic                   cancelled_q, cancelled_d;
    logic                   expired_q, expired_d;
    logic [1:0]             str_q, str_d;
    logic [31:0]            wdata_hold_q, wdata_hold_d;

    logic                   exp_evt;
    logic [EXP_CNT_W-1:0]   cnt_base;

    always_ff @(posedge clkin or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            count_q      <= '0;
            periodic_q   <= 1'b0;
            cnt_q        <= '0;
            cxl_q        <= 1'b0;
            cancelled_q  <= 1'b0;
            expired_q    <= 1'b0;
            str_q        <= '0;
            wdata_hold_q <= '0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            periodic_q   <= periodic_d;
            cnt_q        <= cnt_d;
            cxl_q        <= cxl_d;
            cancelled_q  <= cancelled_d;
            expired_q    <= expired_d;
            str_q        <= str_d;
            wdata_hold_q <= wdata_hold_d;
        end
    end

    // Next-state, latching and expiry bookkeeping
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        periodic_d  = periodic_q;
        cxl_d       = cxl_q;
        cancelled_d = 1'b0;
        exp_evt     = 1'b0;
        cnt_base    = cnt_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    count_d    = req_count;
                    periodic_d = req_periodic;
                    cxl_d      = 1'b0;
                    cnt_base   = '0;
                    // A zero timeout expires immediately without touching the cores
                    if (req_count == 64'd0) begin
                        exp_evt = 1'b1;
                    end else begin
                        state_d = W_LO_VAL;
                    end
                end
            end
            W_LO_VAL, W_HI_VAL, W_LO_DAT, W_HI_DAT, W_HI_CFG, W_LO_CFG: begin
                // The current write is issued this cycle regardless of cancel
                if (cancel) begin
                    state_d = D_HI;
                    cxl_d   = 1'b1;
                end else begin
                    case (state_q)
                        W_LO_VAL: state_d = W_HI_VAL;
                        W_HI_VAL: state_d = W_LO_DAT;
                        W_LO_DAT: state_d = W_HI_DAT;
                        W_HI_DAT: state_d = W_HI_CFG;
                        W_HI_CFG: state_d = W_LO_CFG;
                        default:  state_d = RUN;
                    endcase
                end
            end
            RUN: begin
                exp_evt = hi_irq;
                if (cancel || (hi_irq && !periodic_q)) begin
                    state_d = D_HI;
                    cxl_d   = cancel;
                end
            end
            D_HI: state_d = D_LO;
            D_LO: begin
                state_d     = IDLE;
                cancelled_d = cxl_q;
            end
            default: state_d = IDLE;
        endcase

        cnt_d = cnt_base;
        if (exp_evt && !(&cnt_base)) begin
            cnt_d = cnt_base + 1'b1;
        end

        // Retriggerable stretch of the expiry pulse
        if (exp_evt) begin
            expired_d = 1'b1;
            str_d     = STRETCH;
        end else if (str_q != 2'd0) begin
            expired_d = 1'b1;
            str_d     = str_q - 2'd1;
        end else begin
            expired_d = 1'b0;
            str_d     = 2'd0;
        end
    end

    // Write strobes and data decoded from the current state
    always_comb begin
        lo_val_we    = 4'h0;
        hi_val_we    = 4'h0;
        lo_dat_we    = 4'h0;
        hi_dat_we    = 4'h0;
        lo_cfg_we    = 1'b0;
        hi_cfg_we    = 1'b0;
        ct_wdata     = wdata_hold_q;
        case (state_q)
            W_LO_VAL: begin lo_val_we = 4'hF; ct_wdata = count_q[31:0];  end
            W_HI_VAL: begin hi_val_we = 4'hF; ct_wdata = count_q[63:32]; end
            W_LO_DAT: begin lo_dat_we = 4'hF; ct_wdata = count_q[31:0];  end
            W_HI_DAT: begin hi_dat_we = 4'hF; ct_wdata = count_q[63:32]; end
            // {irq_ena, chain, updown, oneshot, enable}
            W_HI_CFG: begin hi_cfg_we = 1'b1; ct_wdata = {27'd0, 1'b1, 1'b1, 1'b0, ~periodic_q, 1'b1}; end
            W_LO_CFG: begin lo_cfg_we = 1'b1; ct_wdata = {27'd0, 1'b0, 1'b1, 1'b0, ~periodic_q, 1'b1}; end
            D_HI:     begin hi_cfg_we = 1'b1; ct_wdata = 32'd0; end
            D_LO:     begin lo_cfg_we = 1'b1; ct_wdata = 32'd0; end
            default:  ;
        endcase
        wdata_hold_d = ct_wdata;
    end

    assign req_ready  = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign expired    = expired_q;
    assign cancelled  = cancelled_q;
    assign expire_cnt = cnt_q;

endmodule

// File: doc/counter_timer_seq.md
Name: counter_timer_seq

Overview:
- Sequencer that arms, monitors and cancels a chained 64-bit down-counting timer built from a low-word and a high-word counter_timer core.
- A requester hands it a 64-bit count and a mode over a valid/ready handshake.
- The block drives the cores' register-write ports (value, data, config) in a fixed order, then waits for the high word's irq.
- It reports each expiry with a pulse and keeps a saturating expiry count in periodic mode.

Parameters:
EXP_CNT_W, 8, width of the saturating expiry counter
IRQ_STRETCH, 0, extra cycles (0..3) to hold `expired` high after each expiry

Ports:
clkin  in  1  clock
resetn  in  1  reset, asynchronous, active-low
req_valid  in  1  new timer request
req_ready  out  1  high only in IDLE
req_count  in  64  timeout in clkin ticks; [31:0] to low core, [63:32] to high core
req_periodic  in  1  1 = continuous reload, 0 = oneshot
cancel  in  1  level; abort the armed/arming timer
ct_wdata  out  32  shared write data to both cores
lo_val_we  out  4  low core value-reset byte enables
lo_dat_we  out  4  low core current-value byte enables
lo_cfg_we  out  1  low core config write
hi_val_we  out  4  high core value-reset byte enables
hi_dat_we  out  4  high core current-value byte enables
hi_cfg_we  out  1  high core config write
hi_irq  in  1  irq_out of the high core (1-cycle pulse)
busy  out  1  state != IDLE
expired  out  1  expiry pulse
cancelled  out  1  1-cycle pulse on return to IDLE after a cancel
expire_cnt  out  EXP_CNT_W  saturating expiry count since last accept

Behaviour:
- Reset (async, resetn low): state=IDLE; all we strobes 0; ct_wdata=0; busy=0; expired=0; cancelled=0; expire_cnt=0; latched count/mode cleared. Reset mid-sequence abandons it; the cores reset from the same resetn.
- Accept when req_valid && req_ready (cycle 0). On accept:
  - latch req_count and req_periodic;
  - clear expire_cnt.
- Zero count: req_count==0 writes nothing. expired pulses in cycle 1, expire_cnt becomes 1, and the state returns to IDLE.
- Arming states, one cycle each, exactly one strobe active, byte enables 4'b1111:
  - W_LO_VAL (wdata=count[31:0])
  - W_HI_VAL (count[63:32])
  - W_LO_DAT (count[31:0])
  - W_HI_DAT (count[63:32])
  - W_HI_CFG
  - W_LO_CFG
- Config words, as {27'd0, irq_ena, chain, updown, oneshot, enable}:
  - high core: {1,1,0,~periodic,1};
  - low core: {0,1,0,~periodic,1}.
  - The high core is enabled before the low core so the chain's enable_in is valid when the low word starts.
- RUN is entered in cycle 7 after accept. ct_wdata holds its last value outside write states.
- RUN, hi_irq=1: expired asserts next cycle for 1+IRQ_STRETCH cycles, and expire_cnt increments, saturating at all-ones.
  - Oneshot: go to D_HI.
  - Periodic: stay in RUN; the cores reload themselves.
- Disable sequence, one cycle each, wdata=0: D_HI (hi_cfg_we=1), then D_LO (lo_cfg_we=1), then IDLE.
- Cancel:
  - Sampled in RUN, or at the end of any arming state: the current write completes, then the block goes to D_HI. cancelled pulses the cycle IDLE is re-entered.
  - Cancel in IDLE is ignored.
  - cancel and hi_irq in the same RUN cycle: the expiry is counted and pulsed, then the disable sequence runs with cancelled=1.
  - Oneshot natural expiry: cancelled=0.
- A hi_irq seen outside RUN is ignored.
- req_valid while busy is not accepted and must be held by the requester. Back-to-back requests: req_ready returns in the cycle after D_LO.

Test Plan:
- Arm count=64'h0000_0002_0000_0010, oneshot -> cycles 1..6 show strobes in order with wdata 0x10,0x2,0x10,0x2,0x1B,0x0B; pulse hi_irq in RUN -> expired=1 next cycle, expire_cnt=1, then hi_cfg_we, lo_cfg_we with wdata=0, req_ready=1, cancelled=0.
- Periodic count=5, pulse hi_irq 300 times -> 300 expired pulses, state stays RUN, expire_cnt=255 (saturated); then cancel -> D_HI, D_LO, cancelled pulse, IDLE.
- cancel asserted during W_HI_DAT -> W_HI_DAT strobe still issued, no cfg enable writes, disable writes follow, cancelled=1, expire_cnt=0.
- hi_irq and cancel in the same RUN cycle (periodic) -> expired=1, expire_cnt=1, disable sequence, cancelled=1.
- req_count=0 -> no we strobes, expired in cycle 1, expire_cnt=1, busy=0 by cycle 2.
- resetn low mid-sequence (W_LO_DAT) -> all outputs 0 immediately, asynchronously; after release req_ready=1; a spurious hi_irq in IDLE -> no expired.
